pdm_audio_recorder: RTL and testbench

PDM_AUDIO_RECORDER -- requirements
Module: pdm_audio_recorder

---
 rtl/audio_pkg.sv | 20 ++
 rtl/pdm_decimator.sv | 100 ++++++++++
 rtl/pdm_audio_recorder.sv | 130 +++++++++++++
 tb/tb_pdm_audio_recorder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and widths for the PDM audio recorder: record FSM states,
// BRAM address/sample widths and the ones-count to sample conversion.
package audio_pkg;

    localparam int AUDIO_ADDR_W   = 18;
    localparam int AUDIO_SAMPLE_W = 8;
    localparam int AUDIO_CNT_W    = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } rec_state_e;

    // A full window of ones (125) maps to 250, so the sample spans 0..250.
    function automatic logic [AUDIO_SAMPLE_W-1:0] ones_to_sample(input logic [AUDIO_CNT_W-1:0] ones);
        return {ones, 1'b0};
    endfunction

endpackage

// File: rtl/pdm_decimator.sv
// Microphone clock divider, mic_data synchronizer and ones-counting decimator.
// Runs continuously regardless of recorder state.
module pdm_decimator
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int DECIM   = 125
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mic_data,
    output logic                      mic_clk,
    output logic [AUDIO_SAMPLE_W-1:0] sample_out,
    output logic                      sample_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DIV_W-1:0]          div_cnt_r;
    logic [DIV_W-1:0]          div_next_s;
    logic                      mic_clk_r;
    logic                      sync1_r;
    logic                      sync2_r;
    logic                      sample_en_s;
    logic                      last_bit_s;
    logic [BIT_W-1:0]          bit_cnt_r;
    logic [AUDIO_CNT_W-1:0]    ones_cnt_r;
    logic [AUDIO_CNT_W-1:0]    ones_total_s;
    logic [AUDIO_SAMPLE_W-1:0] sample_out_r;
    logic                      sample_tick_r;

    // Next divider value, bit-sample strobe and running ones total.
    always_comb begin
        div_next_s   = {DIV_W{1'b0}};
        sample_en_s  = 1'b0;
        if (div_cnt_r == DIV_W'(CLK_DIV - 1)) begin
            div_next_s  = {DIV_W{1'b0}};
            sample_en_s = 1'b1;
        end else begin
            div_next_s  = div_cnt_r + DIV_W'(1);
            sample_en_s = 1'b0;
        end
        last_bit_s   = (bit_cnt_r == BIT_W'(DECIM - 1));
        ones_total_s = ones_cnt_r + {{(AUDIO_CNT_W-1){1'b0}}, sync2_r};
    end

    // Free-running divider; mic_clk decoded from the next count so it is high for counts 0..CLK_DIV/2-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            mic_clk_r <= 1'b0;
        end else begin
            div_cnt_r <= div_next_s;
            mic_clk_r <= (div_next_s < DIV_W'(CLK_DIV / 2));
        end
    end

    // Two-flop synchronizer for the asynchronous PDM bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= mic_data;
            sync2_r <= sync1_r;
        end
    end

    // Ones counter; the final bit of a window is folded straight into the sample so no bit is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r     <= {BIT_W{1'b0}};
            ones_cnt_r    <= {AUDIO_CNT_W{1'b0}};
            sample_out_r  <= {AUDIO_SAMPLE_W{1'b0}};
            sample_tick_r <= 1'b0;
        end else begin
            sample_tick_r <= 1'b0;
            if (sample_en_s) begin
                if (last_bit_s) begin
                    sample_out_r  <= ones_to_sample(ones_total_s);
                    sample_tick_r <= 1'b1;
                    ones_cnt_r    <= {AUDIO_CNT_W{1'b0}};
                    bit_cnt_r     <= {BIT_W{1'b0}};
                end else begin
                    ones_cnt_r    <= ones_total_s;
                    bit_cnt_r     <= bit_cnt_r + BIT_W'(1);
                end
            end else begin
                ones_cnt_r <= ones_cnt_r;
                bit_cnt_r  <= bit_cnt_r;
            end
        end
    end

    assign mic_clk     = mic_clk_r;
    assign sample_out  = sample_out_r;
    assign sample_tick = sample_tick_r;

endmodule

// File: rtl/pdm_audio_recorder.sv
// PDM microphone recorder: decimates to 8-bit samples and streams them into
// BRAM between rec_start and rec_stop (or until DEPTH samples are stored).
module pdm_audio_recorder
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int DECIM   = 125,
    parameter int DEPTH   = 200000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      rec_start,
    input  logic                      rec_stop,
    input  logic                      mic_data,
    output logic                      mic_clk,
    output logic [AUDIO_SAMPLE_W-1:0] sample_out,
    output logic                      sample_tick,
    output logic                      bram_we,
    output logic [AUDIO_ADDR_W-1:0]   bram_addr,
    output logic [AUDIO_SAMPLE_W-1:0] bram_data_in,
    output logic                      recording,
    output logic                      rec_done,
    output logic [AUDIO_ADDR_W-1:0]   rec_length
);

    logic [AUDIO_SAMPLE_W-1:0] sample_s;
    logic                      tick_s;

    rec_state_e                state_r;
    rec_state_e                state_s;
    logic [AUDIO_ADDR_W-1:0]   wr_cnt_r;
    logic [AUDIO_ADDR_W-1:0]   wr_cnt_s;
    logic                      bram_we_r;
    logic                      we_s;
    logic [AUDIO_ADDR_W-1:0]   bram_addr_r;
    logic [AUDIO_ADDR_W-1:0]   addr_s;
    logic [AUDIO_SAMPLE_W-1:0] bram_data_r;
    logic [AUDIO_SAMPLE_W-1:0] data_s;
    logic [AUDIO_ADDR_W-1:0]   rec_length_r;
    logic [AUDIO_ADDR_W-1:0]   len_s;
    logic                      recording_r;
    logic                      rec_done_r;
    logic                      last_write_s;

    pdm_decimator #(
        .CLK_DIV (CLK_DIV),
        .DECIM   (DECIM)
    ) u_decim (
        .clk         (CLK),
        .rst         (RESET),
        .mic_data    (mic_data),
        .mic_clk     (mic_clk),
        .sample_out  (sample_s),
        .sample_tick (tick_s)
    );

    // Record FSM next state; a stop on a tick cycle still commits that tick's sample.
    always_comb begin
        state_s      = state_r;
        wr_cnt_s     = wr_cnt_r;
        we_s         = 1'b0;
        addr_s       = bram_addr_r;
        data_s       = bram_data_r;
        len_s        = rec_length_r;
        last_write_s = tick_s && (wr_cnt_r == AUDIO_ADDR_W'(DEPTH - 1));
        case (state_r)
            IDLE, DONE: begin
                if (rec_start) begin
                    state_s  = RECORD;
                    wr_cnt_s = {AUDIO_ADDR_W{1'b0}};
                    addr_s   = {AUDIO_ADDR_W{1'b0}};
                end else begin
                    state_s  = state_r;
                end
            end
            RECORD: begin
                if (tick_s) begin
                    we_s     = 1'b1;
                    addr_s   = wr_cnt_r;
                    data_s   = sample_s;
                    wr_cnt_s = wr_cnt_r + AUDIO_ADDR_W'(1);
                end else begin
                    we_s     = 1'b0;
                end
                if (last_write_s || rec_stop) begin
                    state_s = DONE;
                    len_s   = wr_cnt_s;
                end else begin
                    state_s = RECORD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered FSM state and all BRAM/status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            wr_cnt_r     <= {AUDIO_ADDR_W{1'b0}};
            bram_we_r    <= 1'b0;
            bram_addr_r  <= {AUDIO_ADDR_W{1'b0}};
            bram_data_r  <= {AUDIO_SAMPLE_W{1'b0}};
            rec_length_r <= {AUDIO_ADDR_W{1'b0}};
            recording_r  <= 1'b0;
            rec_done_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_cnt_r     <= wr_cnt_s;
            bram_we_r    <= we_s;
            bram_addr_r  <= addr_s;
            bram_data_r  <= data_s;
            rec_length_r <= len_s;
            recording_r  <= (state_s == RECORD);
            rec_done_r   <= (state_s == DONE);
        end
    end

    assign sample_out   = sample_s;
    assign sample_tick  = tick_s;
    assign bram_we      = bram_we_r;
    assign bram_addr    = bram_addr_r;
    assign bram_data_in = bram_data_r;
    assign recording    = recording_r;
    assign rec_done     = rec_done_r;
    assign rec_length   = rec_length_r;

endmodule

// File: tb/tb_pdm_audio_recorder.sv
// Directed bench for pdm_audio_recorder with DEPTH=4: decimation values,
// tick timing, depth limit, stop handling, restart and reset abort.
module tb_pdm_audio_recorder;
    import audio_pkg::*;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        rec_start = 1'b0;
    logic        rec_stop  = 1'b0;
    logic        mic_level = 1'b1;
    logic        alt_mode  = 1'b0;
    logic        alt_bit   = 1'b0;
    logic        mic_data;
    logic        mic_clk;
    logic [7:0]  sample_out;
    logic        sample_tick;
    logic        bram_we;
    logic [17:0] bram_addr;
    logic [7:0]  bram_data_in;
    logic        recording;
    logic        rec_done;
    logic [17:0] rec_length;

    int n_vec = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_bad = 0;
    int cyc   = 0;
    int tick_cyc = 0;
    int prev_cyc = 0;
    int t0 = 0;

    assign mic_data = alt_mode ? alt_bit : mic_level;

    pdm_audio_recorder #(
        .CLK_DIV (50),
        .DECIM   (125),
        .DEPTH   (4)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .rec_start    (rec_start),
        .rec_stop     (rec_stop),
        .mic_data     (mic_data),
        .mic_clk      (mic_clk),
        .sample_out   (sample_out),
        .sample_tick  (sample_tick),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_data_in (bram_data_in),
        .recording    (recording),
        .rec_done     (rec_done),
        .rec_length   (rec_length)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log: total writes, and writes seen while neither recording nor just finished.
    always @(negedge clk) begin
        if (bram_we) begin
            n_wr <= n_wr + 1;
            if (!(recording || rec_done)) n_bad <= n_bad + 1;
        end
    end

    // One PDM bit per mic_clk period when alternating.
    initial begin
        forever begin
            @(posedge mic_clk);
            alt_bit = ~alt_bit;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 7000 && !found; i++) begin
            @(negedge clk);
            if (sample_tick) found = 1'b1;
        end
        if (found) tick_cyc = cyc;
        else chk("tick_timeout", {31'd0, sample_tick}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_mic_clk", {31'd0, mic_clk}, 32'd0);
        chk("rst_sample", {24'd0, sample_out}, 32'd0);
        chk("rst_tick", {31'd0, sample_tick}, 32'd0);
        chk("rst_we", {31'd0, bram_we}, 32'd0);
        chk("rst_addr", {14'd0, bram_addr}, 32'd0);
        chk("rst_data", {24'd0, bram_data_in}, 32'd0);
        chk("rst_recording", {31'd0, recording}, 32'd0);
        chk("rst_done", {31'd0, rec_done}, 32'd0);
        chk("rst_length", {14'd0, rec_length}, 32'd0);

        // A: mic held at 1, record straight out of reset until DEPTH fills.
        rst = 1'b0;
        t0 = cyc;
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        chk("a_recording", {31'd0, recording}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            prev_cyc = tick_cyc;
            wait_tick();
            if (i == 0) chk("a_first_tick_lat", {31'd0, (tick_cyc - t0 >= 6247) && (tick_cyc - t0 <= 6253)}, 32'd1);
            else chk("a_tick_period", tick_cyc - prev_cyc, 32'd6250);
            chk("a_sample_ones", {24'd0, sample_out}, 32'd250);
            @(negedge clk);
            chk("a_we", {31'd0, bram_we}, 32'd1);
            chk("a_addr", {14'd0, bram_addr}, i);
            chk("a_data", {24'd0, bram_data_in}, 32'd250);
            if (i == 1) begin
                rec_start = 1'b1;
                @(negedge clk);
                rec_start = 1'b0;
            end
        end
        chk("a_done", {31'd0, rec_done}, 32'd1);
        chk("a_not_recording", {31'd0, recording}, 32'd0);
        chk("a_length", {14'd0, rec_length}, 32'd4);

        // Fifth tick in DONE: no write; then start+stop together, start wins.
        wait_tick();
        mic_level = 1'b0;
        rec_start = 1'b1;
        rec_stop  = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        chk("b_start_wins", {31'd0, recording}, 32'd1);
        @(negedge clk);
        chk("a_no_write_in_done", n_wr, 32'd4);

        // B: mic at 0, then alternating; stop mid-window after 2 writes.
        wait_tick();
        alt_mode = 1'b1;
        chk("b_sample_zeros", {24'd0, sample_out}, 32'd0);
        @(negedge clk);
        chk("b_restart_addr", {14'd0, bram_addr}, 32'd0);
        chk("b_data_zero", {24'd0, bram_data_in}, 32'd0);
        wait_tick();
        chk("b_sample_alt", {31'd0, (sample_out == 8'd124) || (sample_out == 8'd126)}, 32'd1);
        @(negedge clk);
        chk("b_addr1", {14'd0, bram_addr}, 32'd1);
        repeat (100) @(negedge clk);
        rec_stop = 1'b1;
        @(negedge clk);
        rec_stop = 1'b0;
        chk("b_done", {31'd0, rec_done}, 32'd1);
        chk("b_length", {14'd0, rec_length}, 32'd2);

        // C: stop coinciding with the third tick still writes it.
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        wait_tick();
        @(negedge clk);
        chk("c_addr0", {14'd0, bram_addr}, 32'd0);
        wait_tick();
        @(negedge clk);
        chk("c_addr1", {14'd0, bram_addr}, 32'd1);
        wait_tick();
        rec_stop = 1'b1;
        @(negedge clk);
        rec_stop = 1'b0;
        chk("c_stop_we", {31'd0, bram_we}, 32'd1);
        chk("c_stop_addr", {14'd0, bram_addr}, 32'd2);
        chk("c_done", {31'd0, rec_done}, 32'd1);
        chk("c_length", {14'd0, rec_length}, 32'd3);
        @(negedge clk);
        chk("c_we_after", {31'd0, bram_we}, 32'd0);

        // D: reset on a tick cycle during RECORD suppresses the pending write.
        rec_start = 1'b1;
        @(negedge clk);
        rec_start = 1'b0;
        wait_tick();
        wait_tick();
        rst = 1'b1;
        #1;
        chk("d_we", {31'd0, bram_we}, 32'd0);
        chk("d_recording", {31'd0, recording}, 32'd0);
        chk("d_done", {31'd0, rec_done}, 32'd0);
        chk("d_length", {14'd0, rec_length}, 32'd0);
        chk("d_addr", {14'd0, bram_addr}, 32'd0);
        chk("d_sample", {24'd0, sample_out}, 32'd0);
        chk("d_tick", {31'd0, sample_tick}, 32'd0);
        repeat (3) @(negedge clk);
        chk("d_we_held", {31'd0, bram_we}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("d_idle_after", {31'd0, recording}, 32'd0);
        chk("total_writes", n_wr, 32'd10);
        chk("we_outside_rec", n_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
